ram_arbiter: RTL and testbench

//  Shares the single-port data RAM (byte address, word-indexed internally, combinational read,

---
 rtl/ram_arbiter_pkg.sv | 18 +
 rtl/ram_arbiter_rr_pick.sv | 30 +++
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned DEF_NUM_REQ    = 2;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Requester index width for the supported range of 2..4 requesters.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from ptr+1, or fixed with index 0 highest.
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned IDX_W      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'(FIXED_PRIO ? (k - 1) : ((32'(ptr) + k) % NUM_REQ));
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: req/ack per requester, one registered access per cycle.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ram_store,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]         ram_data,
  input  logic [DATA_WIDTH-1:0]         ram_result,
  output logic [31:0]                   access_count
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, ptr_q, winner;
  logic                    found;
  logic [NUM_REQ-1:0]      eligible;
  logic                    cmd_we_q, sel_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, sel_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, sel_wdata;
  logic [31:0]             cnt_q;

  // The owner's req is stale during its ack cycle, so it sits out one round.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && !(state_q == ACCESS && owner_q == IDX_W'(i));
    end
  end

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .FIXED_PRIO(FIXED_PRIO),
    .IDX_W     (IDX_W)
  ) u_pick (
    .eligible(eligible),
    .ptr     (ptr_q),
    .found   (found),
    .winner  (winner)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = found ? ACCESS : IDLE;
    ack       = '0;
    ram_store = 1'b0;
    if (state_q == ACCESS) begin
      ack[owner_q] = 1'b1;
      ram_store    = cmd_we_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (found) begin
        owner_q     <= winner;
        ptr_q       <= winner;
        cmd_we_q    <= sel_we;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign ram_address  = cmd_addr_q;
  assign ram_data     = cmd_wdata_q;
  assign rdata        = ram_result;
  assign access_count = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter, each with a behavioural RAM.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NR = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [NR-1:0]    req [2];
  logic [NR-1:0]    we [2];
  logic [NR*AW-1:0] addr [2];
  logic [NR*DW-1:0] wdata [2];
  logic [NR-1:0]    ack [2];
  logic [DW-1:0]    rdata [2];
  logic             ram_store [2];
  logic [AW-1:0]    ram_address [2];
  logic [DW-1:0]    ram_data [2];
  logic [DW-1:0]    ram_result [2];
  logic [31:0]      count [2];

  logic [31:0] mem0 [256] = '{default: '0};
  logic [31:0] mem1 [256] = '{default: '0};
  always @(posedge clock) if (ram_store[0]) mem0[ram_address[0][9:2]] <= ram_data[0];
  always @(posedge clock) if (ram_store[1]) mem1[ram_address[1][9:2]] <= ram_data[1];
  assign ram_result[0] = mem0[ram_address[0][9:2]];
  assign ram_result[1] = mem1[ram_address[1][9:2]];

  ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) u_rr (
    .clock(clock), .reset(reset), .req(req[0]), .req_we(we[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .ram_store(ram_store[0]),
    .ram_address(ram_address[0]), .ram_data(ram_data[0]), .ram_result(ram_result[0]),
    .access_count(count[0]));

  ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) u_fx (
    .clock(clock), .reset(reset), .req(req[1]), .req_we(we[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .ram_store(ram_store[1]),
    .ram_address(ram_address[1]), .ram_data(ram_data[1]), .ram_result(ram_result[1]),
    .access_count(count[1]));

  typedef struct {
    int          idx;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_ack [2];
  int   t_start;

  function automatic void push(input int d, input int idx, input bit rd, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.rd   = rd;
    e.data = data;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t          e;
    logic [NR-1:0] exp_ack;
    int            qs;
    forever begin
      @(negedge clock);
      if (ack[d] != '0) begin
        last_ack[d] = cyc;
        n_vec++;
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          n_err++;
          $display("FAIL sb%0d: unexpected ack %b at cycle %0d", d, ack[d], cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          exp_ack = NR'(1) << e.idx;
          if (ack[d] !== exp_ack || (e.rd && rdata[d] !== e.data)) begin
            n_err++;
            $display("FAIL sb%0d: ack %b rdata 0x%08h, expected ack %b rdata 0x%08h (read=%0d) cycle %0d",
                     d, ack[d], rdata[d], exp_ack, e.data, e.rd, cyc);
          end
        end
      end
    end
  endtask

  // n back-to-back transactions from one requester, keeping req high between them.
  task automatic drive(input int d, input int i, input int n, input bit w,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0, input bit chk_lat);
    int t0;
    bit got;
    for (int k = 0; k < n; k++) begin
      we[d][i]               = w;
      addr[d][i*AW +: AW]    = a0 + AW'(4 * k);
      wdata[d][i*DW +: DW]   = d0 + DW'(k);
      req[d][i]              = 1'b1;
      t0  = cyc;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clock);
        got = ack[d][i];
      end
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: dut%0d req%0d got no ack", d, i);
      end else if (chk_lat) begin
        check($sformatf("latency dut%0d req%0d", d, i), 32'(cyc - t0), 32'd1);
      end
      @(posedge clock); #1;
    end
    req[d][i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset  = 1'b1;
    req[0] = '0;
    req[1] = '0;
    @(posedge clock); #1;
    reset  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0; last_ack[d] = 0;
    end
    fork
      mon(0);
      mon(1);
    join_none

    // Reset values
    #2;
    check("rst ack", 32'(ack[0]), 32'd0);
    check("rst ram_store", 32'(ram_store[0]), 32'd0);
    check("rst ram_address", 32'(ram_address[0]), 32'd0);
    check("rst ram_data", ram_data[0], 32'd0);
    check("rst access_count", count[0], 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset during an ACCESS write: nothing committed
    we[0][0] = 1'b1;
    addr[0][0 +: AW] = 10'h010;
    wdata[0][0 +: DW] = 32'hDEAD_BEEF;
    req[0][0] = 1'b1;
    @(posedge clock); #1;
    check("access ack before reset", 32'(ack[0]), 32'd1);
    check("access store before reset", 32'(ram_store[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("ack under reset", 32'(ack[0]), 32'd0);
    check("store under reset", 32'(ram_store[0]), 32'd0);
    req[0] = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("word 4 after reset", mem0[4], 32'd0);
    check("count after reset", count[0], 32'd0);

    // Single write then read from requester 0
    do_reset();
    push(0, 0, 1'b0, 32'd0);
    drive(0, 0, 1, 1'b1, 10'h020, 32'h1234_5678, 1'b1);
    push(0, 0, 1'b1, 32'h1234_5678);
    drive(0, 0, 1, 1'b0, 10'h020, 32'd0, 1'b1);
    repeat (2) @(negedge clock);
    check("count write/read", count[0], 32'd2);

    // Round-robin contention: strict alternation, no idle cycles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(0, 0, 1'b0, 32'd0);
      push(0, 1, 1'b0, 32'd0);
    end
    t_start = cyc;
    fork
      drive(0, 0, 4, 1'b1, 10'h100, 32'h0000_1000, 1'b0);
      drive(0, 1, 4, 1'b1, 10'h200, 32'h0000_2000, 1'b0);
    join
    check("rr last ack cycle", 32'(last_ack[0] - t_start), 32'd8);
    repeat (2) @(negedge clock);
    check("count rr", count[0], 32'd8);

    // Fixed priority: after a req0 grant, req0 still wins a simultaneous start
    do_reset();
    push(1, 0, 1'b0, 32'd0);
    drive(1, 0, 1, 1'b1, 10'h040, 32'h0000_0001, 1'b0);
    for (int k = 0; k < 7; k++) push(1, k % 2, 1'b0, 32'd0);
    fork
      drive(1, 0, 4, 1'b1, 10'h080, 32'h0000_0010, 1'b0);
      drive(1, 1, 3, 1'b1, 10'h0C0, 32'h0000_0020, 1'b0);
    join
    repeat (2) @(negedge clock);
    check("count fixed", count[1], 32'd8);

    // Read-after-write across requesters
    do_reset();
    push(0, 1, 1'b0, 32'd0);
    push(0, 0, 1'b1, 32'hA5A5_A5A5);
    fork
      drive(0, 1, 1, 1'b1, 10'h3FC, 32'hA5A5_A5A5, 1'b0);
      begin
        @(posedge clock); #1;
        drive(0, 0, 1, 1'b0, 10'h3FC, 32'd0, 1'b0);
      end
    join
    check("word 255 written", mem0[255], 32'hA5A5_A5A5);

    // Counter wrap
    do_reset();
    @(negedge clock);
    force u_rr.cnt_q = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    release u_rr.cnt_q;
    check("count preset", count[0], 32'hFFFF_FFFF);
    push(0, 0, 1'b0, 32'd0);
    drive(0, 0, 1, 1'b1, 10'h0F0, 32'h0000_0005, 1'b0);
    repeat (2) @(negedge clock);
    check("count wrap", count[0], 32'd0);

    repeat (3) @(negedge clock);
    check("sb0 drained", 32'(q0.size()), 32'd0);
    check("sb1 drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
